// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared mode encodings and controller states
package cpu_clk_pkg;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_BURST
  } cpu_state_e;

  function automatic cpu_state_e mode_state(input logic [1:0] m);
    case (m)
      MODE_HALT: return ST_HALT;
      MODE_RUN:  return ST_RUN;
      MODE_STEP: return ST_STEP;
      default:   return ST_BURST;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - step button synchroniser, debouncer and rising-edge strobe
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_req_o
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          step_req_q;

  // cnt_q counts consecutive synchronised samples that disagree with the accepted level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      step_req_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      step_req_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_q    <= sync_q[1];
        cnt_q      <= '0;
        step_req_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign step_req_o = step_req_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - CPU advance-strobe controller: reset hold, halt/run/step/burst
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int DEB_CYCLES = 16,
  parameter int BURST_N    = 8,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             step_btn,
  output logic             cpu_clk_en,
  output logic             cpu_n_reset,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int REM_W  = $clog2(BURST_N + 1);

  cpu_state_e        st_q;
  logic [1:0]        mode_q;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0] hold_q;
  logic [REM_W-1:0]  rem_q;
  logic              busy_q, en_q, nrst_q;
  logic [CNT_W-1:0]  cyc_q;
  logic              step_req, tick, mode_chg, burst_load;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk_i      (clk),
    .rst_i      (reset),
    .btn_i      (step_btn),
    .step_req_o (step_req)
  );

  // A burst load parks the prescaler on its terminal value so the first pulse leaves next cycle
  always_comb begin
    tick       = (presc_q == div_sel);
    mode_chg   = (st_q != ST_HOLD) && (mode != mode_q);
    burst_load = (st_q == ST_BURST) && !busy_q && step_req && !mode_chg;
    presc_d    = tick ? '0 : presc_q + DIV_W'(1);
    if ((st_q == ST_HOLD) || mode_chg) begin
      presc_d = '0;
    end else if (burst_load) begin
      presc_d = div_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_HOLD;
      mode_q  <= MODE_HALT;
      presc_q <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      nrst_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      mode_q  <= mode;
      presc_q <= presc_d;
      en_q    <= 1'b0;
      if (!nrst_q) begin
        cyc_q <= '0;
      end else if (en_q) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (st_q == ST_HOLD) begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          st_q   <= mode_state(mode);
          nrst_q <= 1'b1;
        end else begin
          hold_q <= hold_q + HOLD_W'(1);
        end
      end else if (mode_chg) begin
        st_q   <= mode_state(mode);
        busy_q <= 1'b0;
        rem_q  <= '0;
      end else begin
        case (st_q)
          ST_RUN:  en_q <= tick;
          ST_STEP: en_q <= step_req;
          ST_BURST: begin
            if (busy_q) begin
              if (tick) begin
                en_q  <= 1'b1;
                rem_q <= rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                  busy_q <= 1'b0;
                end
              end
            end else if (burst_load) begin
              busy_q <= 1'b1;
              rem_q  <= REM_W'(BURST_N);
            end
          end
          default: en_q <= 1'b0;
        endcase
      end
    end
  end

  assign cpu_clk_en  = en_q;
  assign cpu_n_reset = nrst_q;
  assign busy        = busy_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - self-checking bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;
  import cpu_clk_pkg::*;

  localparam int DIV_W = 24;
  localparam int DEB   = 16;
  localparam int BN    = 8;
  localparam int RH    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = MODE_HALT;
  logic [DIV_W-1:0] div_sel = '0;
  logic             step_btn = 1'b0;
  logic             en, nrst, busy;
  logic [CNT_W-1:0] cnt;
  logic             en_w, nrst_w, busy_w;
  logic [3:0]       cnt_w;

  int checks = 0;
  int passed = 0;
  int exp_count = 0;
  int cyc_no = 0;
  int busy_n = 0;
  int pulse_t[$];
  bit pulse_b[$];

  always #5 clk = ~clk;

  cpu_clock_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(DEB), .BURST_N(BN), .RST_HOLD(RH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .cpu_clk_en(en), .cpu_n_reset(nrst), .busy(busy), .cycle_count(cnt)
  );

  cpu_clock_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(DEB), .BURST_N(BN), .RST_HOLD(RH), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .cpu_clk_en(en_w), .cpu_n_reset(nrst_w), .busy(busy_w), .cycle_count(cnt_w)
  );

  always @(negedge clk) begin
    cyc_no++;
    if (en === 1'b1) begin
      pulse_t.push_back(cyc_no);
      pulse_b.push_back(busy);
    end
    if (busy === 1'b1) busy_n++;
  end

  task automatic press(input int hold);
    int nb;
    nb = $urandom_range(1, 5);
    for (int i = 0; i < nb; i++) begin
      step_btn = 1'b1;
      repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
      step_btn = 1'b0;
      repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
    end
    step_btn = 1'b1;
    repeat (hold) @(negedge clk);
  endtask

  task automatic release_btn();
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b0;
      repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
      step_btn = 1'b1;
      repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
    end
    step_btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_btn = 1'b0;
    #1;
    checks++; if (nrst !== 1'b0) $display("FAIL reset_nrst: got %b want 0", nrst); else passed++;
    checks++; if (en !== 1'b0) $display("FAIL reset_en: got %b want 0", en); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (cnt !== '0) $display("FAIL reset_count: got %0d want 0", cnt); else passed++;
    repeat (3) begin
      @(negedge clk);
      checks++; if (en !== 1'b0 || busy !== 1'b0) $display("FAIL reset_hold_quiet: en=%b busy=%b want 0 0", en, busy); else passed++;
    end
    reset = 1'b0;
    exp_count = 0;
    for (int k = 1; k <= RH + 2; k++) begin
      @(negedge clk);
      checks++; if (nrst !== (k >= RH)) $display("FAIL release_nrst k=%0d: got %b want %b", k, nrst, (k >= RH)); else passed++;
      checks++; if (en !== 1'b0) $display("FAIL release_en k=%0d: got %b want 0", k, en); else passed++;
      checks++; if (cnt !== '0 || cnt_w !== '0) $display("FAIL release_count k=%0d: got %0d/%0d want 0", k, cnt, cnt_w); else passed++;
    end
  endtask

  task automatic test_run(input int div, input int ncyc);
    logic exp_en;
    @(negedge clk);
    mode = MODE_HALT;
    repeat (2) @(negedge clk);
    div_sel = DIV_W'(div);
    mode = MODE_RUN;
    for (int t = 0; t <= ncyc; t++) begin
      @(negedge clk);
      exp_en = (t > 0) && (t % (div + 1) == 0);
      checks++; if (en !== exp_en) $display("FAIL run_en div=%0d t=%0d: got %b want %b", div, t, en, exp_en); else passed++;
      checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL run_count div=%0d t=%0d: got %0d want %0d", div, t, cnt, CNT_W'(exp_count)); else passed++;
      checks++; if (cnt_w !== 4'(exp_count)) $display("FAIL run_count_w div=%0d t=%0d: got %0d want %0d", div, t, cnt_w, 4'(exp_count)); else passed++;
      if (exp_en) exp_count++;
    end
    mode = MODE_HALT;
  endtask

  task automatic test_step();
    int p0;
    @(negedge clk);
    mode = MODE_STEP;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      #1 p0 = pulse_t.size();
      press(DEB + 4 + $urandom_range(0, 6));
      release_btn();
      #1;
      checks++; if (pulse_t.size() - p0 !== 1) $display("FAIL step_pulses press=%0d: got %0d want 1", p, pulse_t.size() - p0); else passed++;
      exp_count++;
    end
    checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL step_count: got %0d want %0d", cnt, exp_count); else passed++;
    mode = MODE_HALT;
  endtask

  task automatic test_halt();
    int p0;
    @(negedge clk);
    mode = MODE_HALT;
    repeat (2) @(negedge clk);
    #1 p0 = pulse_t.size();
    press(DEB + 6);
    release_btn();
    #1;
    checks++; if (pulse_t.size() - p0 !== 0) $display("FAIL halt_pulses: got %0d want 0", pulse_t.size() - p0); else passed++;
    checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL halt_count: got %0d want %0d", cnt, exp_count); else passed++;
  endtask

  task automatic test_burst(input int div, input bit second);
    int p0, b0, w, np;
    @(negedge clk);
    mode = MODE_HALT;
    div_sel = DIV_W'(div);
    repeat (2) @(negedge clk);
    mode = MODE_BURST;
    repeat (3) @(negedge clk);
    #1;
    p0 = pulse_t.size();
    b0 = busy_n;
    press(4);
    w = 0;
    while (busy !== 1'b1 && w < 4 * DEB) begin
      @(negedge clk);
      w++;
    end
    checks++; if (busy !== 1'b1) $display("FAIL burst_start div=%0d: got busy=%b want 1 within %0d cycles", div, busy, 4 * DEB); else passed++;
    step_btn = 1'b0;
    if (second) begin
      repeat (DEB + 4) @(negedge clk);
      step_btn = 1'b1;
      repeat (DEB + 4) @(negedge clk);
      step_btn = 1'b0;
    end
    repeat (BN * (div + 1) + 2 * DEB) @(negedge clk);
    #1;
    np = pulse_t.size() - p0;
    checks++; if (np !== BN) $display("FAIL burst_pulses div=%0d second=%0d: got %0d want %0d", div, second, np, BN); else passed++;
    for (int i = 1; i < BN && i < np; i++) begin
      checks++;
      if (pulse_t[p0 + i] - pulse_t[p0 + i - 1] !== div + 1)
        $display("FAIL burst_spacing div=%0d i=%0d: got %0d want %0d", div, i, pulse_t[p0 + i] - pulse_t[p0 + i - 1], div + 1);
      else passed++;
    end
    if (np >= BN) begin
      checks++; if (pulse_b[p0] !== 1'b1) $display("FAIL burst_first_busy: got %b want 1", pulse_b[p0]); else passed++;
      checks++; if (pulse_b[p0 + BN - 1] !== 1'b0) $display("FAIL burst_last_busy: got %b want 0", pulse_b[p0 + BN - 1]); else passed++;
    end
    checks++; if (busy_n - b0 !== 1 + (BN - 1) * (div + 1)) $display("FAIL burst_busy_len div=%0d: got %0d want %0d", div, busy_n - b0, 1 + (BN - 1) * (div + 1)); else passed++;
    exp_count += BN;
    checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL burst_count: got %0d want %0d", cnt, exp_count); else passed++;
    mode = MODE_HALT;
  endtask

  task automatic test_burst_abort();
    int p0, w, div;
    div = $urandom_range(1, 4);
    @(negedge clk);
    mode = MODE_HALT;
    div_sel = DIV_W'(div);
    repeat (2) @(negedge clk);
    mode = MODE_BURST;
    repeat (3) @(negedge clk);
    #1 p0 = pulse_t.size();
    press(4);
    w = 0;
    while (pulse_t.size() - p0 < 3 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++; if (pulse_t.size() - p0 !== 3) $display("FAIL abort_reach3: got %0d pulses want 3", pulse_t.size() - p0); else passed++;
    mode = MODE_HALT;
    step_btn = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    repeat (40) @(negedge clk);
    #1;
    checks++; if (pulse_t.size() - p0 !== 3) $display("FAIL abort_pulses: got %0d want 3", pulse_t.size() - p0); else passed++;
    exp_count += 3;
    checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL abort_count: got %0d want %0d", cnt, exp_count); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int p0, w;
    @(negedge clk);
    mode = MODE_HALT;
    div_sel = DIV_W'(2);
    repeat (2) @(negedge clk);
    mode = MODE_BURST;
    repeat (3) @(negedge clk);
    #1 p0 = pulse_t.size();
    press(4);
    w = 0;
    while (pulse_t.size() - p0 < 2 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++; if (pulse_t.size() - p0 !== 2) $display("FAIL midreset_reach2: got %0d pulses want 2", pulse_t.size() - p0); else passed++;
    p0 = pulse_t.size();
    test_reset();
    repeat (20) @(negedge clk);
    #1;
    checks++; if (pulse_t.size() - p0 !== 0) $display("FAIL midreset_pulses: got %0d want 0", pulse_t.size() - p0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_wrap();
    test_reset();
    test_run(0, 20);
    repeat (2) @(negedge clk);
    checks++; if (cnt_w !== 4'(exp_count)) $display("FAIL wrap_count_w: got %0d want %0d", cnt_w, 4'(exp_count)); else passed++;
    checks++; if (cnt !== CNT_W'(exp_count)) $display("FAIL wrap_count: got %0d want %0d", cnt, exp_count); else passed++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_run(3, 40);
    test_run(0, 20);
    test_run($urandom_range(1, 6), 30);
    test_step();
    test_halt();
    test_burst(1, 1'b0);
    test_burst($urandom_range(6, 9), 1'b1);
    test_burst_abort();
    test_reset_mid_burst();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 24, width of prescaler counter and div_sel.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, cycles step_btn must be stable to be accepted (>=2).
REQ-003 SHALL have parameter BURST_N, default 8, cpu_clk_en pulses per burst (>=1).
REQ-004 SHALL have parameter RST_HOLD, default 4, cycles cpu_n_reset stays low after reset release (>=1).
REQ-005 SHALL have parameter CNT_W, default 16, width of cycle_count.
REQ-006 SHALL have port clk  in  1  single system clock, all logic rising-edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-009 SHALL have port div_sel  in  DIV_W  prescaler terminal value; tick period = div_sel+1 cycles.
REQ-010 SHALL have port step_btn  in  1  raw asynchronous push button, active-high.
REQ-011 SHALL have port cpu_clk_en  out  1  one-cycle CPU advance strobe.
REQ-012 SHALL have port cpu_n_reset  out  1  active-low CPU reset.
REQ-013 SHALL have port busy  out  1  high while a burst is in progress.
REQ-014 SHALL have port cycle_count  out  CNT_W  number of cpu_clk_en pulses since CPU reset.

Function
REQ-015 SHALL pass step_btn through a 2-FF synchroniser, then a debouncer updating its accepted level only after DEB_CYCLES consecutive equal samples.
REQ-016 SHALL generate step_req, one cycle high, on each 0->1 transition of the accepted level.
REQ-017 SHALL run the prescaler 0..div_sel, asserting tick when count==div_sel then returning to 0; div_sel=0 gives tick every cycle.
REQ-018 SHALL implement states HOLD, HALT, RUN, STEP, BURST.
REQ-019 HOLD: cpu_n_reset=0, cpu_clk_en=0; after RST_HOLD cycles go to the state selected by mode.
REQ-020 HALT (mode 00): cpu_clk_en=0; step_req ignored.
REQ-021 RUN (mode 01): cpu_clk_en = tick.
REQ-022 STEP (mode 10): step_req in cycle N gives exactly one cpu_clk_en in cycle N+1, independent of prescaler.
REQ-023 BURST (mode 11): step_req with busy=0 loads remaining=BURST_N and sets busy; each tick while busy issues cpu_clk_en and decrements; busy clears in the cycle of the final pulse.
REQ-024 SHALL ignore step_req arriving while busy=1.
REQ-025 SHALL register mode; on any change of the registered value clear prescaler, clear busy/remaining, discard pending step, then enter the new mode's state next cycle.
REQ-026 SHALL increment cycle_count by 1 on each cpu_clk_en, wrapping 2^CNT_W-1 -> 0.
REQ-027 SHALL clear cycle_count while cpu_n_reset=0.
REQ-028 SHALL never assert cpu_clk_en while cpu_n_reset=0 or in HALT.
REQ-029 SHALL take a div_sel change without restart: if count > new div_sel, count continues to wrap at 2^DIV_W.

Reset
REQ-030 SHALL, while reset=1, force cpu_n_reset=0, cpu_clk_en=0, busy=0, cycle_count=0, prescaler=0, debouncer level=0, state=HOLD.
REQ-031 SHALL, on reset assertion mid-burst or mid-step, abort it immediately with no further cpu_clk_en.
REQ-032 SHALL release cpu_n_reset synchronously, exactly RST_HOLD clk cycles after reset deasserts.

Structure
REQ-033 SHALL place mode encodings (MODE_HALT/RUN/STEP/BURST) and the state enumeration in shared package cpu_clk_pkg.
REQ-034 SHALL implement synchroniser+debouncer+edge detect as sub-module btn_debounce (parameter DEB_CYCLES), instanced once.
REQ-035 SHALL not create derived clocks; CPU advances via cpu_clk_en only.

Verification
REQ-036 Reset pulse, RST_HOLD=4 -> cpu_n_reset low until 4 cycles after reset falls, cpu_clk_en=0 and cycle_count=0 throughout.
REQ-037 RUN, div_sel=3, 40 cycles -> cpu_clk_en every 4th cycle, cycle_count=10.
REQ-038 STEP, step_btn bouncing 5 toggles then stable high 20 cycles, DEB_CYCLES=16 -> exactly one cpu_clk_en, cycle_count=1.
REQ-039 BURST, div_sel=1, BURST_N=8, one press plus second press during burst -> exactly 8 pulses 2 cycles apart, busy high 15 cycles, second press ignored.
REQ-040 BURST mid-way, mode switched to HALT after 3 pulses -> busy=0 next cycle, no further pulses, cycle_count=3.
REQ-041 CNT_W=4, RUN div_sel=0 for 17 enables -> cycle_count wraps 15->0, reads 1.
